// File: rtl/divider_if.sv
// Operand/result bundle shared between the calculator evaluator and the divider.
interface divider_if;
  logic              eval;
  logic              done;
  logic              error;
  logic              signA;
  logic              signB;
  logic [33:0]       mantA;
  logic [33:0]       mantB;
  logic signed [6:0] expA;
  logic signed [6:0] expB;
  logic              signRes;
  logic [33:0]       mantRes;
  logic signed [6:0] expRes;

  modport master (
    output eval, signA, signB, mantA, mantB, expA, expB,
    input  done, error, signRes, mantRes, expRes
  );

  modport slave (
    input  eval, signA, signB, mantA, mantB, expA, expB,
    output done, error, signRes, mantRes, expRes
  );
endinterface

// File: rtl/divider.sv
// Sequential decimal floating-point divider: A / B with 34-bit mantissas and
// signed 7-bit base-10 exponents. The dividend is scaled by powers of ten until
// the quotient fills the 34-bit range, then a 72-step restoring binary division
// produces the truncated quotient mantissa.
module divider (
  input  logic     clock,
  input  logic     reset,
  divider_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCALE, S_DIVIDE, S_FINAL, S_DONE} state_t;

  localparam logic [6:0] LAST_ITER = 7'd71;

  state_t              state_q, state_d;
  logic                eval_prev_q, eval_prev_d;
  logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [33:0]         mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  logic signed [6:0]   exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic                sign_q, sign_d;
  logic signed [8:0]   exp_acc_q, exp_acc_d;
  logic [71:0]         num_q, num_d;
  logic [33:0]         rem_q, rem_d;
  logic [6:0]          cnt_q, cnt_d;
  logic                err_path_q, err_path_d;
  logic                zero_path_q, zero_path_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                sign_res_q, sign_res_d;
  logic [33:0]         mant_res_q, mant_res_d;
  logic signed [6:0]   exp_res_q, exp_res_d;

  logic [71:0]         num_x10;
  logic [71:0]         scale_lim;
  logic [34:0]         rem_sh;

  // Final exponent must fit the signed 7-bit result field.
  function automatic logic exp_in_range(input logic signed [8:0] e);
    return (e >= -9'sd64) && (e <= 9'sd63);
  endfunction

  // N*10 via shifts; N stays below 2^68 so the product fits 72 bits.
  function automatic logic [71:0] times10(input logic [71:0] n);
    return (n << 3) + (n << 1);
  endfunction

  assign bus.done    = done_q;
  assign bus.error   = error_q;
  assign bus.signRes = sign_res_q;
  assign bus.mantRes = mant_res_q;
  assign bus.expRes  = exp_res_q;

  // Next-state, datapath and result computation.
  always_comb begin
    state_d     = state_q;
    eval_prev_d = bus.eval;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    mant_a_d    = mant_a_q;
    mant_b_d    = mant_b_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    sign_d      = sign_q;
    exp_acc_d   = exp_acc_q;
    num_d       = num_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    err_path_d  = err_path_q;
    zero_path_d = zero_path_q;
    done_d      = 1'b0;
    error_d     = error_q;
    sign_res_d  = sign_res_q;
    mant_res_d  = mant_res_q;
    exp_res_d   = exp_res_q;
    num_x10     = times10(num_q);
    scale_lim   = {4'd0, mant_b_q, 34'd0};
    rem_sh      = {rem_q, num_q[71]};

    case (state_q)
      S_IDLE: begin
        if (bus.eval && !eval_prev_q) begin
          sign_a_d = bus.signA;
          sign_b_d = bus.signB;
          mant_a_d = bus.mantA;
          mant_b_d = bus.mantB;
          exp_a_d  = bus.expA;
          exp_b_d  = bus.expB;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        sign_d      = sign_a_q ^ sign_b_q;
        exp_acc_d   = {{2{exp_a_q[6]}}, exp_a_q} - {{2{exp_b_q[6]}}, exp_b_q};
        num_d       = {38'd0, mant_a_q};
        rem_d       = '0;
        err_path_d  = (mant_b_q == '0);
        zero_path_d = (mant_b_q != '0) && (mant_a_q == '0);
        if ((mant_b_q == '0) || (mant_a_q == '0)) state_d = S_FINAL;
        else                                      state_d = S_SCALE;
      end
      S_SCALE: begin
        if (num_x10 < scale_lim) begin
          num_d     = num_x10;
          exp_acc_d = exp_acc_q - 9'sd1;
        end else begin
          cnt_d   = '0;
          rem_d   = '0;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (rem_sh >= {1'b0, mant_b_q}) begin
          rem_d = rem_sh[33:0] - mant_b_q;
          num_d = {num_q[70:0], 1'b1};
        end else begin
          rem_d = rem_sh[33:0];
          num_d = {num_q[70:0], 1'b0};
        end
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == LAST_ITER) state_d = S_FINAL;
      end
      S_FINAL: begin
        // A zero dividend yields an exact zero regardless of exponents.
        if (err_path_q || (!zero_path_q && !exp_in_range(exp_acc_q))) begin
          error_d    = 1'b1;
          sign_res_d = 1'b0;
          mant_res_d = '0;
          exp_res_d  = '0;
        end else if (zero_path_q) begin
          error_d    = 1'b0;
          sign_res_d = 1'b0;
          mant_res_d = '0;
          exp_res_d  = '0;
        end else begin
          error_d    = 1'b0;
          sign_res_d = sign_q;
          mant_res_d = num_q[33:0];
          exp_res_d  = exp_acc_q[6:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      eval_prev_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      mant_a_q    <= '0;
      mant_b_q    <= '0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      sign_q      <= 1'b0;
      exp_acc_q   <= '0;
      num_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      err_path_q  <= 1'b0;
      zero_path_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      sign_res_q  <= 1'b0;
      mant_res_q  <= '0;
      exp_res_q   <= '0;
    end else begin
      state_q     <= state_d;
      eval_prev_q <= eval_prev_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      mant_a_q    <= mant_a_d;
      mant_b_q    <= mant_b_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      sign_q      <= sign_d;
      exp_acc_q   <= exp_acc_d;
      num_q       <= num_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      err_path_q  <= err_path_d;
      zero_path_q <= zero_path_d;
      done_q      <= done_d;
      error_q     <= error_d;
      sign_res_q  <= sign_res_d;
      mant_res_q  <= mant_res_d;
      exp_res_q   <= exp_res_d;
    end
  end
endmodule

// File: tb/tb_divider.sv
// Bench for the decimal floating-point divider: directed vector table,
// multi-cycle corner sequences and randomized operands against a model.
module tb_divider;
  typedef struct {
    logic              sa;
    logic              sb;
    logic [33:0]       ma;
    logic [33:0]       mb;
    logic signed [6:0] ea;
    logic signed [6:0] eb;
    logic              es;
    logic [33:0]       em;
    logic signed [6:0] ee;
    logic              err;
    int                lat;
  } vec_t;

  localparam logic [33:0] M_MAX = 34'd17179869183;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  divider_if bus_if();

  divider u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: scale A by the largest power of ten keeping the quotient
  // below 2^34, divide with plain integer arithmetic, apply range rules.
  task automatic model(input logic sa, input logic sb, input logic [33:0] ma,
                       input logic [33:0] mb, input logic signed [6:0] ea,
                       input logic signed [6:0] eb, output vec_t v);
    logic [127:0] n, lim, q;
    int k, ex;
    v.sa = sa; v.sb = sb; v.ma = ma; v.mb = mb; v.ea = ea; v.eb = eb;
    v.es = 1'b0; v.em = '0; v.ee = '0; v.err = 1'b0; v.lat = 4;
    if (mb == 0) begin
      v.err = 1'b1;
    end else if (ma != 0) begin
      n = 128'(ma);
      lim = 128'(mb) * (128'd1 << 34);
      k = 0;
      while (n * 128'd10 < lim) begin
        n = n * 128'd10;
        k++;
      end
      q = n / 128'(mb);
      ex = int'(ea) - int'(eb) - k;
      v.lat = k + 77;
      if (ex < -64 || ex > 63) begin
        v.err = 1'b1;
      end else begin
        v.es = sa ^ sb;
        v.em = q[33:0];
        v.ee = 7'(ex);
      end
    end
  endtask

  // Runs one operation. glitch: cycle in which a spurious eval is raised
  // (0 = none). abort_at: cycle in which reset is asserted (0 = none).
  // post: cycles after done during which no further done may appear.
  task automatic do_op(input vec_t v, input string name, input int glitch,
                       input int abort_at, input int post);
    int cyc, done_cyc, extra;
    logic p_s, p_e;
    logic [33:0] p_m;
    logic signed [6:0] p_x;
    @(negedge clk);
    bus_if.signA = v.sa; bus_if.signB = v.sb;
    bus_if.mantA = v.ma; bus_if.mantB = v.mb;
    bus_if.expA  = v.ea; bus_if.expB  = v.eb;
    bus_if.eval  = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    bus_if.eval  = 1'b0;
    bus_if.signA = 1'($urandom); bus_if.signB = 1'($urandom);
    bus_if.mantA = {2'($urandom), 32'($urandom)};
    bus_if.mantB = {2'($urandom), 32'($urandom)};
    bus_if.expA  = 7'($urandom); bus_if.expB = 7'($urandom);
    done_cyc = 0;
    p_s = 1'b0; p_e = 1'b0; p_m = '0; p_x = '0;
    while (cyc < 130) begin
      if (bus_if.done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_at != 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({name, " abort done"},  longint'(bus_if.done),    0);
        chk({name, " abort error"}, longint'(bus_if.error),   0);
        chk({name, " abort sign"},  longint'(bus_if.signRes), 0);
        chk({name, " abort mant"},  longint'(bus_if.mantRes), 0);
        chk({name, " abort exp"},   longint'(bus_if.expRes),  0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 120; i++) begin
          @(posedge clk); #1;
          if (bus_if.done) extra++;
        end
        chk({name, " abort no done"}, extra, 0);
        return;
      end
      bus_if.eval = (glitch != 0 && cyc == glitch);
      p_s = bus_if.signRes; p_e = bus_if.error;
      p_m = bus_if.mantRes; p_x = bus_if.expRes;
      @(posedge clk); #1;
      cyc++;
    end
    bus_if.eval = 1'b0;
    if (done_cyc == 0) begin
      chk({name, " timeout waiting for done"}, cyc, v.lat);
      return;
    end
    chk({name, " latency"}, done_cyc, v.lat);
    chk({name, " error"},   longint'(bus_if.error),   longint'(v.err));
    chk({name, " sign"},    longint'(bus_if.signRes), longint'(v.es));
    chk({name, " mant"},    longint'(bus_if.mantRes), longint'(v.em));
    chk({name, " exp"},     longint'(bus_if.expRes),  longint'(v.ee));
    chk({name, " early mant"}, longint'(p_m), longint'(v.em));
    chk({name, " early exp"},  longint'(p_x), longint'(v.ee));
    chk({name, " early flags"}, longint'({p_s, p_e}), longint'({v.es, v.err}));
    extra = 0;
    for (int i = 0; i < post; i++) begin
      @(posedge clk); #1;
      if (bus_if.done) extra++;
    end
    chk({name, " single done"}, extra, 0);
    chk({name, " hold mant"}, longint'(bus_if.mantRes), longint'(v.em));
  endtask

  vec_t  vecs[13];
  string names[13];
  vec_t  rv;

  initial begin
    bus_if.eval = 1'b0;
    bus_if.signA = 1'b0; bus_if.signB = 1'b0;
    bus_if.mantA = '0;   bus_if.mantB = '0;
    bus_if.expA  = '0;   bus_if.expB  = '0;

    //            sa    sb    ma      mb     ea       eb      es    em                ee       err   lat
    vecs[0]  = '{1'b0, 1'b0, 34'd1, 34'd3, 7'sd0,   7'sd0,  1'b0, 34'd3333333333,  -7'sd10, 1'b0, 87};
    vecs[1]  = '{1'b1, 1'b0, 34'd6, 34'd2, 7'sd5,   7'sd2,  1'b1, 34'd3000000000,  -7'sd6,  1'b0, 86};
    vecs[2]  = '{1'b0, 1'b0, M_MAX, 34'd1, 7'sd3,  -7'sd4,  1'b0, M_MAX,            7'sd7,  1'b0, 77};
    vecs[3]  = '{1'b1, 1'b0, 34'd12345, 34'd0, 7'sd5, 7'sd1, 1'b0, 34'd0,           7'sd0,  1'b1, 4};
    vecs[4]  = '{1'b1, 1'b0, 34'd0, 34'd7, 7'sd0,   7'sd0,  1'b0, 34'd0,            7'sd0,  1'b0, 4};
    vecs[5]  = '{1'b0, 1'b0, 34'd1, 34'd3, -7'sd60, 7'sd10, 1'b0, 34'd0,            7'sd0,  1'b1, 87};
    vecs[6]  = '{1'b0, 1'b0, 34'd1, 34'd1, 7'sd63, -7'sd64, 1'b0, 34'd0,            7'sd0,  1'b1, 87};
    vecs[7]  = '{1'b0, 1'b0, 34'd1, 34'd1, -7'sd54, 7'sd0,  1'b0, 34'd10000000000, -7'sd64, 1'b0, 87};
    vecs[8]  = '{1'b0, 1'b0, 34'd1, 34'd1, -7'sd55, 7'sd0,  1'b0, 34'd0,            7'sd0,  1'b1, 87};
    vecs[9]  = '{1'b0, 1'b1, M_MAX, 34'd1, 7'sd63,  7'sd0,  1'b1, M_MAX,            7'sd63, 1'b0, 77};
    vecs[10] = '{1'b0, 1'b0, M_MAX, 34'd1, 7'sd63, -7'sd1,  1'b0, 34'd0,            7'sd0,  1'b1, 77};
    vecs[11] = '{1'b0, 1'b0, 34'd1, M_MAX, 7'sd0,   7'sd0,  1'b0, 34'd5820766091,  -7'sd20, 1'b0, 97};
    vecs[12] = '{1'b1, 1'b1, 34'd0, 34'd0, 7'sd2,   7'sd3,  1'b0, 34'd0,            7'sd0,  1'b1, 4};
    names = '{"one_third", "six_half", "max_one", "div_zero", "zero_num",
              "underflow", "overflow", "exp_min", "exp_below", "exp_max",
              "exp_above", "k_twenty", "zero_zero"};

    repeat (3) @(posedge clk);
    #1;
    chk("reset done",  longint'(bus_if.done),    0);
    chk("reset error", longint'(bus_if.error),   0);
    chk("reset sign",  longint'(bus_if.signRes), 0);
    chk("reset mant",  longint'(bus_if.mantRes), 0);
    chk("reset exp",   longint'(bus_if.expRes),  0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) do_op(vecs[i], names[i], 0, 0, 3);

    do_op(vecs[0], "second_eval", 20, 0, 100);
    do_op(vecs[1], "reset_abort", 0, 40, 0);
    do_op(vecs[1], "after_abort", 0, 0, 3);

    for (int i = 0; i < 20; i++) begin
      logic [33:0] ma, mb;
      ma = {2'($urandom), 32'($urandom)};
      mb = {2'($urandom), 32'($urandom)};
      if ($urandom_range(1, 0) == 1) ma = 34'($urandom_range(100000, 1));
      if ($urandom_range(1, 0) == 1) mb = 34'($urandom_range(1000, 1));
      if (ma == 0) ma = 34'd1;
      if (mb == 0) mb = 34'd1;
      model(1'($urandom), 1'($urandom), ma, mb, 7'($urandom), 7'($urandom), rv);
      do_op(rv, $sformatf("rand%0d", i), 0, 0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
